// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default widths for the Wishbone initiator bridge.
package wb_pkg;

  localparam int WB_DATA_WIDTH_DEF = 32;
  localparam int WB_ADDR_WIDTH_DEF = 32;
  localparam int WB_SEL_WIDTH_DEF  = WB_DATA_WIDTH_DEF / 8;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WB_DATA_WIDTH_DEF-1:0] rdata;
    logic                         err;
  } rsp_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating cycle counter that flags the last permitted cycle.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      count <= '0;
    end else if (enable_i && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero limit means the timeout is disabled entirely.
  assign expired_o = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - single-transfer Wishbone classic initiator with request/response channels.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DATA_WIDTH_DEF,
  parameter int WB_ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
  parameter int WB_SEL_WIDTH   = WB_SEL_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
  input  logic [WB_SEL_WIDTH-1:0]  req_sel_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic                     wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

  state_t state, state_next;
  logic   expired, terminate;

  logic                     cyc_d, we_d, rsp_valid_d, rsp_err_d;
  logic [WB_ADDR_WIDTH-1:0] addr_d;
  logic [WB_DATA_WIDTH-1:0] data_d, rsp_rdata_d;
  logic [WB_SEL_WIDTH-1:0]  sel_d;

  wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (state != BUS),
    .enable_i  ((state == BUS) && !wb_ack_i && !wb_err_i),
    .expired_o (expired)
  );

  assign terminate = wb_err_i || wb_ack_i || expired;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid_i && req_ready_o) state_next = BUS;
      BUS:     if (terminate) state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the output registers; everything holds unless the state acts on it.
  always_comb begin
    cyc_d       = wb_cyc_o;
    we_d        = wb_we_o;
    addr_d      = wb_addr_o;
    data_d      = wb_data_o;
    sel_d       = wb_sel_o;
    rsp_valid_d = rsp_valid_o;
    rsp_err_d   = rsp_err_o;
    rsp_rdata_d = rsp_rdata_o;
    case (state)
      IDLE: if (req_valid_i && req_ready_o) begin
        cyc_d  = 1'b1;
        we_d   = req_we_i;
        addr_d = req_addr_i;
        data_d = req_wdata_i;
        sel_d  = req_sel_i;
      end
      BUS: if (terminate) begin
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = wb_err_i || !wb_ack_i;
        rsp_rdata_d = (!wb_err_i && wb_ack_i && !wb_we_o) ? wb_data_i : '0;
      end
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      wb_cyc_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_sel_o    <= '0;
    end else begin
      req_ready_o <= (state_next == IDLE);
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rsp_rdata_d;
      wb_cyc_o    <= cyc_d;
      wb_we_o     <= we_d;
      wb_addr_o   <= addr_d;
      wb_data_o   <= data_d;
      wb_sel_o    <= sel_d;
    end
  end

  assign wb_stb_o = wb_cyc_o;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - directed bench for wb_master_bridge with a small machine-timer responder.
module tb_wb_master_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata, wb_addr, wb_wdata, wb_rdata;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
  logic [3:0]  wb_sel;

  logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata, b_wb_addr, b_wb_wdata;
  logic        b_wb_we, b_wb_stb, b_wb_cyc;
  logic [3:0]  b_wb_sel;

  int vectors = 0;
  int miscompares = 0;

  wb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wb_addr_o(wb_addr), .wb_data_o(wb_wdata), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
    .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_data_i(wb_rdata)
  );

  wb_master_bridge #(.TIMEOUT_CYCLES(0)) dut_noto (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(1'b0),
    .req_addr_i(32'h0000_0100), .req_wdata_i(32'h0), .req_sel_i(4'hF),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(1'b0), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .wb_addr_o(b_wb_addr), .wb_data_o(b_wb_wdata), .wb_we_o(b_wb_we), .wb_sel_o(b_wb_sel),
    .wb_stb_o(b_wb_stb), .wb_cyc_o(b_wb_cyc), .wb_ack_i(1'b0), .wb_err_i(1'b0), .wb_data_i(32'h0)
  );

  // Responder: 0 = machine timer registers, 1 = silent, 2 = ack and err together.
  int          mode = 0;
  logic        r_ack = 1'b0, r_err = 1'b0, force_ack = 1'b0;
  logic [31:0] r_data = '0;
  logic [31:0] mem [0:7];

  always @(posedge clk) begin
    r_ack <= 1'b0;
    r_err <= 1'b0;
    if (wb_cyc && wb_stb && !r_ack && !r_err) begin
      if (mode == 0) begin
        r_ack <= 1'b1;
        if (wb_we) mem[wb_addr[4:2]] <= wb_wdata;
        else       r_data <= mem[wb_addr[4:2]];
      end else if (mode == 2) begin
        r_ack  <= 1'b1;
        r_err  <= 1'b1;
        r_data <= 32'hDEAD_BEEF;
      end
    end
  end

  assign wb_ack   = r_ack | force_ack;
  assign wb_err   = r_err;
  assign wb_rdata = r_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, output int cycles, output int acks);
    req_we = we; req_addr = addr; req_wdata = wdata; req_sel = sel; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bus_addr", wb_addr, addr);
    check("bus_we", {31'b0, wb_we}, {31'b0, we});
    check("bus_stb", {31'b0, wb_stb}, 32'd1);
    if (we) check("bus_wdata", wb_wdata, wdata);
    cycles = 0;
    acks = 0;
    while (wb_cyc && cycles < 2000) begin
      cycles++;
      if (wb_ack) acks++;
      @(negedge clk);
    end
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cyc_n, ack_n, seen;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_stb", {31'b0, wb_stb}, 32'd0);
    check("rst_we", {31'b0, wb_we}, 32'd0);
    check("rst_addr", wb_addr, 32'd0);
    check("rst_wdata", wb_wdata, 32'd0);
    check("rst_sel", {28'b0, wb_sel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Timer write / readback at mtimecmp lo.
    do_req(1'b1, 32'h08, 32'h0000_1234, 4'hF, cyc_n, ack_n);
    check("wr08_cyc_cycles", cyc_n, 2);
    check("wr08_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("wr08_err", {31'b0, rsp_err}, 32'd0);
    check("wr08_rdata", rsp_rdata, 32'd0);
    rsp_take();
    do_req(1'b0, 32'h08, 32'h0, 4'hF, cyc_n, ack_n);
    check("rd08_rdata", rsp_rdata, 32'h0000_1234);
    check("rd08_err", {31'b0, rsp_err}, 32'd0);
    rsp_take();

    do_req(1'b1, 32'h10, 32'h5, 4'hF, cyc_n, ack_n);
    rsp_take();
    do_req(1'b0, 32'h10, 32'h0, 4'hF, cyc_n, ack_n);
    check("rd10_rdata", rsp_rdata, 32'h0000_0005);
    check("rd10_err", {31'b0, rsp_err}, 32'd0);
    check("rd10_cyc_cycles", cyc_n, 2);
    check("rd10_single_ack", ack_n, 1);
    rsp_take();

    // Simultaneous ack and err: err wins, data dropped.
    mode = 2;
    do_req(1'b0, 32'h10, 32'h0, 4'hF, cyc_n, ack_n);
    check("ackerr_valid", {31'b0, rsp_valid}, 32'd1);
    check("ackerr_err", {31'b0, rsp_err}, 32'd1);
    check("ackerr_rdata", rsp_rdata, 32'd0);
    rsp_take();

    // Silent responder with a 4-cycle limit.
    mode = 1;
    do_req(1'b0, 32'h40, 32'h0, 4'hF, cyc_n, ack_n);
    check("to_cyc_cycles", cyc_n, 4);
    check("to_valid", {31'b0, rsp_valid}, 32'd1);
    check("to_err", {31'b0, rsp_err}, 32'd1);
    check("to_rdata", rsp_rdata, 32'd0);
    rsp_take();

    // Response back-pressure with a new request already waiting.
    mode = 0;
    do_req(1'b0, 32'h10, 32'h0, 4'hF, cyc_n, ack_n);
    req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h77; req_sel = 4'hF; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'h5);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_cyc", {31'b0, wb_cyc}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_rsp_drop", {31'b0, rsp_valid}, 32'd0);
    check("bp_no_accept_yet", {31'b0, wb_cyc}, 32'd0);
    check("bp_ready_again", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accept_next", {31'b0, wb_cyc}, 32'd1);
    check("bp_accept_addr", wb_addr, 32'h08);
    cyc_n = 0;
    while (wb_cyc && cyc_n < 50) begin cyc_n++; @(negedge clk); end
    check("bp_second_done", {31'b0, rsp_valid}, 32'd1);
    rsp_take();

    // Timeout disabled: the cycle never ends on its own.
    b_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    cyc_n = 0;
    while (b_wb_cyc && cyc_n < 1000) begin cyc_n++; @(negedge clk); end
    check("noto_cyc_cycles", cyc_n, 1000);
    check("noto_still_cyc", {31'b0, b_wb_cyc}, 32'd1);
    check("noto_no_rsp", {31'b0, b_rsp_valid}, 32'd0);

    // Reset in the middle of a bus cycle.
    mode = 1;
    req_we = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_bus", {31'b0, wb_cyc}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("midrst_stb", {31'b0, wb_stb}, 32'd0);
    check("midrst_rsp", {31'b0, rsp_valid}, 32'd0);
    check("midrst_noto_cyc", {31'b0, b_wb_cyc}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || wb_cyc) seen = 1;
      @(negedge clk);
    end
    check("midrst_no_late_rsp", seen, 0);

    // Stray ack while idle.
    mode = 0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check("stray_rsp", {31'b0, rsp_valid}, 32'd0);
    check("stray_cyc", {31'b0, wb_cyc}, 32'd0);
    check("stray_ready", {31'b0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
